// File: rtl/sccomp_trace_checker_if.sv
// Bus between the sccomp trace checker and its environment: trace loading,
// run control, the CPU's observed pc/aluout, and the pass/fail report.
interface sccomp_trace_checker_if #(
    parameter int AW = 6,
    parameter int CW = 16
);
    logic          start;
    logic [AW:0]   trace_len;
    logic          tw_en;
    logic [AW-1:0] tw_addr;
    logic [31:0]   tw_pc;
    logic [31:0]   tw_alu;
    logic          tw_chk;
    logic [31:0]   pc;
    logic [31:0]   aluout;
    logic          busy;
    logic          done;
    logic          pass;
    logic [1:0]    cause;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_err;
    logic [CW-1:0] cycles;

    modport master (
        output start, trace_len, tw_en, tw_addr, tw_pc, tw_alu, tw_chk, pc, aluout,
        input  busy, done, pass, cause, err_count, first_err, cycles
    );
    modport slave (
        input  start, trace_len, tw_en, tw_addr, tw_pc, tw_alu, tw_chk, pc, aluout,
        output busy, done, pass, cause, err_count, first_err, cycles
    );
endinterface

// File: rtl/sccomp_trace_checker.sv
// Run-time checker for sccomp: compares per-cycle pc/aluout against a preloaded
// expected trace and reports pass/fail, cause and diagnostic counters.
module sccomp_trace_checker #(
    parameter int DEPTH       = 64,
    parameter int AW          = 6,
    parameter int CW          = 16,
    parameter int TIMEOUT     = 1000,
    parameter int HALT_REPEAT = 4,
    parameter bit STOP_ON_ERR = 1'b1
) (
    input  logic                  clk,
    input  logic                  clrn,
    sccomp_trace_checker_if.slave bus
);
    localparam int HW = $clog2(HALT_REPEAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
    state_t state_q, state_d;

    logic [31:0] mem_pc  [DEPTH];
    logic [31:0] mem_alu [DEPTH];
    logic        mem_chk [DEPTH];

    logic [AW:0]   len_q, len_eff;
    logic [AW-1:0] idx_q;
    logic [31:0]   prev_pc_q;
    logic          prev_vld_q;
    logic [HW-1:0] halt_q, halt_d;
    logic [AW:0]   err_q, err_d;
    logic [AW-1:0] ferr_q;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [1:0]    cause_q, cause_d;
    logic          mis, last, halted, tmo, go;

    assign len_eff = (bus.trace_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.trace_len;
    assign go      = bus.start && (state_q != RUN);

    // Trace memory: no reset, writable whenever no run is in progress.
    always_ff @(posedge clk) begin
        if (bus.tw_en && state_q != RUN && int'(bus.tw_addr) < DEPTH) begin
            mem_pc[bus.tw_addr]  <= bus.tw_pc;
            mem_alu[bus.tw_addr] <= bus.tw_alu;
            mem_chk[bus.tw_addr] <= bus.tw_chk;
        end
    end

    always_comb begin
        mis     = (bus.pc != mem_pc[idx_q]) ||
                  (mem_chk[idx_q] && (bus.aluout != mem_alu[idx_q]));
        last    = ({1'b0, idx_q} == len_q - 1'b1);
        // The first compared cycle has no predecessor, so it never counts as a repeat.
        halt_d  = (prev_vld_q && bus.pc == prev_pc_q) ? halt_q + 1'b1 : '0;
        halted  = (halt_d == HW'(HALT_REPEAT));
        cyc_d   = cyc_q + 1'b1;
        tmo     = (cyc_d == CW'(TIMEOUT));
        err_d   = (mis && err_q != '1) ? err_q + 1'b1 : err_q;
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            RUN: begin
                if (mis && STOP_ON_ERR) begin
                    state_d = FAIL;
                    cause_d = 2'd1;
                end else if (last) begin
                    state_d = (err_d == '0) ? PASS : FAIL;
                    cause_d = (err_d == '0) ? 2'd0 : 2'd1;
                end else if (halted) begin
                    state_d = FAIL;
                    cause_d = 2'd2;
                end else if (tmo) begin
                    state_d = FAIL;
                    cause_d = 2'd3;
                end
            end
            default: begin
                if (go) begin
                    state_d = (len_eff == '0) ? PASS : RUN;
                    cause_d = 2'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cause_q    <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            cyc_q      <= '0;
            err_q      <= '0;
            ferr_q     <= '0;
            halt_q     <= '0;
            prev_pc_q  <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            cause_q <= cause_d;
            if (go) begin
                len_q      <= len_eff;
                idx_q      <= '0;
                cyc_q      <= '0;
                err_q      <= '0;
                ferr_q     <= '0;
                halt_q     <= '0;
                prev_vld_q <= 1'b0;
            end else if (state_q == RUN) begin
                idx_q      <= idx_q + 1'b1;
                cyc_q      <= cyc_d;
                err_q      <= err_d;
                halt_q     <= halt_d;
                prev_pc_q  <= bus.pc;
                prev_vld_q <= 1'b1;
                if (mis && err_q == '0) ferr_q <= idx_q;
            end
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == PASS) || (state_q == FAIL);
    assign bus.pass      = (state_q == PASS);
    assign bus.cause     = cause_q;
    assign bus.err_count = err_q;
    assign bus.first_err = ferr_q;
    assign bus.cycles    = cyc_q;
endmodule

// File: tb/tb_sccomp_trace_checker.sv
// Bench for sccomp_trace_checker: two instances (stop-on-error with long timeout,
// count-and-continue with TIMEOUT=5) driven identically and checked against a trace model.
module tb_sccomp_trace_checker;
    localparam int AW = 6, CW = 16, DEPTH = 64, MAXC = 140;

    logic clk  = 1'b0;
    logic clrn = 1'b1;
    always #5 clk = ~clk;

    sccomp_trace_checker_if #(.AW(AW), .CW(CW)) ifa ();
    sccomp_trace_checker_if #(.AW(AW), .CW(CW)) ifb ();

    sccomp_trace_checker #(.DEPTH(DEPTH), .AW(AW), .CW(CW), .TIMEOUT(1000),
                           .HALT_REPEAT(4), .STOP_ON_ERR(1'b1))
        dut_a (.clk(clk), .clrn(clrn), .bus(ifa.slave));
    sccomp_trace_checker #(.DEPTH(DEPTH), .AW(AW), .CW(CW), .TIMEOUT(5),
                           .HALT_REPEAT(4), .STOP_ON_ERR(1'b0))
        dut_b (.clk(clk), .clrn(clrn), .bus(ifb.slave));

    assign ifb.start     = ifa.start;
    assign ifb.trace_len = ifa.trace_len;
    assign ifb.tw_en     = ifa.tw_en;
    assign ifb.tw_addr   = ifa.tw_addr;
    assign ifb.tw_pc     = ifa.tw_pc;
    assign ifb.tw_alu    = ifa.tw_alu;
    assign ifb.tw_chk    = ifa.tw_chk;
    assign ifb.pc        = ifa.pc;
    assign ifb.aluout    = ifa.aluout;

    // expected trace (tp/ta/tc) and the CPU behaviour driven per cycle (sp/sa)
    logic [31:0] tp [DEPTH];
    logic [31:0] ta [DEPTH];
    bit          tc [DEPTH];
    logic [31:0] sp [MAXC];
    logic [31:0] sa [MAXC];

    int nvec = 0;
    int nerr = 0;

    typedef struct { bit pass; int cause; int errc; int ferr; int cyc; } res_t;

    // Walk the run one compared cycle at a time and stop at the first deciding event.
    function automatic res_t model(input int raw, input bit stop, input int tmo);
        res_t r;
        int len, hc;
        bit m;
        r.pass = 1'b1; r.cause = 0; r.errc = 0; r.ferr = 0; r.cyc = 0;
        len = (raw > DEPTH) ? DEPTH : raw;
        if (len == 0) return r;
        hc = 0;
        for (int k = 0; k < MAXC; k++) begin
            m  = (sp[k] != tp[k]) || (tc[k] && sa[k] != ta[k]);
            hc = (k > 0 && sp[k] == sp[k-1]) ? hc + 1 : 0;
            if (m) begin
                if (r.errc == 0) r.ferr = k;
                r.errc++;
            end
            r.cyc = k + 1;
            if (m && stop) begin r.pass = 0; r.cause = 1; return r; end
            if (k == len - 1) begin
                r.pass  = (r.errc == 0);
                r.cause = (r.errc == 0) ? 0 : 1;
                return r;
            end
            if (hc >= 4)      begin r.pass = 0; r.cause = 2; return r; end
            if (r.cyc >= tmo) begin r.pass = 0; r.cause = 3; return r; end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare(input string nm, input res_t ra, input res_t rb);
        chk({nm, ".a.done"},  64'(ifa.done),      64'(1));
        chk({nm, ".a.pass"},  64'(ifa.pass),      64'(ra.pass));
        chk({nm, ".a.cause"}, 64'(ifa.cause),     64'(ra.cause));
        chk({nm, ".a.errc"},  64'(ifa.err_count), 64'(ra.errc));
        chk({nm, ".a.ferr"},  64'(ifa.first_err), 64'(ra.ferr));
        chk({nm, ".a.cyc"},   64'(ifa.cycles),    64'(ra.cyc));
        chk({nm, ".b.done"},  64'(ifb.done),      64'(1));
        chk({nm, ".b.pass"},  64'(ifb.pass),      64'(rb.pass));
        chk({nm, ".b.cause"}, 64'(ifb.cause),     64'(rb.cause));
        chk({nm, ".b.errc"},  64'(ifb.err_count), 64'(rb.errc));
        chk({nm, ".b.ferr"},  64'(ifb.first_err), 64'(rb.ferr));
        chk({nm, ".b.cyc"},   64'(ifb.cycles),    64'(rb.cyc));
    endtask

    task automatic set_linear();
        for (int i = 0; i < DEPTH; i++) begin
            tp[i] = 32'(4 * i); ta[i] = '0; tc[i] = 1'b0;
        end
        for (int k = 0; k < MAXC; k++) begin
            sp[k] = 32'(4 * k); sa[k] = '0;
        end
    endtask

    task automatic gen_random(output int raw);
        int mode, pt;
        raw  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(65, 127)) : int'($urandom_range(0, 64));
        mode = $urandom_range(0, 2);
        pt   = $urandom_range(0, 40);
        for (int i = 0; i < DEPTH; i++) begin
            tp[i] = (mode == 1 && i > pt) ? 32'(4 * pt) : 32'(4 * i);
            ta[i] = $urandom;
            tc[i] = 1'($urandom_range(0, 1));
        end
        for (int k = 0; k < MAXC; k++) begin
            sp[k] = (k < DEPTH) ? tp[k] : 32'(4 * k);
            sa[k] = (k < DEPTH) ? ta[k] : 32'h0;
            if ($urandom_range(0, (mode == 2) ? 8 : 40) == 0) sp[k] = sp[k] ^ 32'h10;
            if ($urandom_range(0, 11) == 0) sa[k] = ~sa[k];
        end
    endtask

    // The last trace write shares its cycle with start.
    task automatic load_and_start(input int raw);
        int len;
        len = (raw > DEPTH) ? DEPTH : raw;
        for (int i = 0; i < len; i++) begin
            ifa.tw_en     = 1'b1;
            ifa.tw_addr   = AW'(i);
            ifa.tw_pc     = tp[i];
            ifa.tw_alu    = ta[i];
            ifa.tw_chk    = tc[i];
            ifa.start     = (i == len - 1);
            ifa.trace_len = (AW+1)'(raw);
            @(posedge clk); #1;
        end
        if (len == 0) begin
            ifa.start     = 1'b1;
            ifa.trace_len = (AW+1)'(raw);
            @(posedge clk); #1;
        end
        ifa.start = 1'b0;
        ifa.tw_en = 1'b0;
    endtask

    task automatic run_case(input string nm, input int raw);
        res_t ra, rb;
        int kmin;
        ra   = model(raw, 1'b1, 1000);
        rb   = model(raw, 1'b0, 5);
        kmin = (ra.cyc < rb.cyc) ? ra.cyc : rb.cyc;
        load_and_start(raw);
        if (raw != 0) chk({nm, ".busy"}, 64'({ifa.busy, ifb.busy}), 64'(2'b11));
        for (int k = 0; k < MAXC && !(ifa.done && ifb.done); k++) begin
            ifa.pc      = sp[k];
            ifa.aluout  = sa[k];
            // junk writes and a stray start while running must have no effect
            ifa.tw_en   = 1'b1;
            ifa.tw_addr = AW'($urandom);
            ifa.tw_pc   = $urandom;
            ifa.tw_alu  = $urandom;
            ifa.tw_chk  = 1'b1;
            ifa.start   = (k == 1 && kmin >= 2);
            @(posedge clk); #1;
        end
        ifa.tw_en = 1'b0;
        ifa.start = 1'b0;
        compare(nm, ra, rb);
    endtask

    initial begin
        int raw;
        ifa.start = 1'b0; ifa.trace_len = '0; ifa.tw_en = 1'b0; ifa.tw_addr = '0;
        ifa.tw_pc = '0; ifa.tw_alu = '0; ifa.tw_chk = 1'b0; ifa.pc = '0; ifa.aluout = '0;
        #1 clrn = 1'b0;
        #2;
        chk("reset.a", 64'({ifa.busy, ifa.done, ifa.pass, ifa.cause, ifa.err_count, ifa.first_err, ifa.cycles}), 64'(0));
        chk("reset.b", 64'({ifb.busy, ifb.done, ifb.pass, ifb.cause, ifb.err_count, ifb.first_err, ifb.cycles}), 64'(0));
        @(posedge clk); @(posedge clk); #1 clrn = 1'b1;
        @(posedge clk); #1;

        set_linear();
        run_case("linear4", 4);
        set_linear(); sp[2] = 32'h10;
        run_case("pcmis", 4);
        set_linear(); tc[1] = 1'b1; tc[3] = 1'b1; ta[1] = 32'd5; ta[3] = 32'd7;
        run_case("alumis", 4);
        set_linear();
        for (int i = 2; i < DEPTH; i++) tp[i] = 32'd8;
        for (int k = 2; k < MAXC; k++) sp[k] = 32'd8;
        run_case("halt", 8);
        set_linear();
        run_case("timeout", 8);
        run_case("len0", 0);
        run_case("clamp", 100);

        // asynchronous reset in the middle of a run
        set_linear();
        load_and_start(8);
        for (int k = 0; k < 2; k++) begin
            ifa.pc = sp[k]; @(posedge clk); #1;
        end
        chk("midrun.busy", 64'({ifa.busy, ifb.busy}), 64'(2'b11));
        #1 clrn = 1'b0;
        #1;
        chk("midrst.a", 64'({ifa.busy, ifa.done, ifa.pass, ifa.cause, ifa.err_count, ifa.first_err, ifa.cycles}), 64'(0));
        chk("midrst.b", 64'({ifb.busy, ifb.done, ifb.pass, ifb.cause, ifb.err_count, ifb.first_err, ifb.cycles}), 64'(0));
        #1 clrn = 1'b1;
        @(posedge clk); #1;
        run_case("postrst", 6);

        for (int n = 0; n < 25; n++) begin
            gen_random(raw);
            run_case($sformatf("rnd%0d", n), raw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/sccomp_trace_checker.md
# sccomp_trace_checker

Synthesizable run-time checker for the single-cycle computer (`sccomp`). It watches the CPU's per-cycle `pc` and `aluout` and compares them against a preloaded expected-execution trace. It flags mismatches, early halts and runaway execution, and reports pass/fail with diagnostic counters. It replaces manual waveform inspection of the CPU testbench and can sit beside the CPU on an FPGA as well as in simulation.

## Interface
- `DEPTH`, default 64: number of trace entries.
- `AW`, default 6: trace address width; DEPTH ≤ 2^AW.
- `CW`, default 16: cycle-counter width.
- `TIMEOUT`, default 1000: maximum RUN cycles before a forced fail; must be < 2^CW.
- `HALT_REPEAT`, default 4: consecutive cycles with an unchanged `pc` that count as a halt.
- `STOP_ON_ERR`, default 1: 1 = fail on the first mismatch; 0 = count mismatches and continue.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `clrn` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse; accepted in IDLE only.
- `trace_len` in AW+1: number of entries to check; sampled on `start`; values > DEPTH are clamped to DEPTH.
- `tw_en` in 1: trace write strobe; honoured in IDLE only.
- `tw_addr` in AW: trace write address.
- `tw_pc` in 32: expected `pc`.
- `tw_alu` in 32: expected `aluout`.
- `tw_chk` in 1: 1 = check `aluout` for this entry.
- `pc` in 32: CPU program counter.
- `aluout` in 32: CPU ALU result.
- `busy` out 1: high in RUN.
- `done` out 1: high in PASS or FAIL; held until `start` or reset.
- `pass` out 1: high in PASS.
- `cause` out 2: fail cause. 0 none, 1 mismatch, 2 early halt, 3 timeout.
- `err_count` out AW+1: number of mismatching entries; saturates at all-ones.
- `first_err` out AW: trace index of the first mismatch.
- `cycles` out CW: number of RUN cycles consumed.

## Operation
- States: IDLE, RUN, PASS, FAIL.
- Reset: state goes to IDLE and every output goes to 0. Trace memory contents are undefined after reset and must be rewritten.
- IDLE:
  - `tw_en` writes {`tw_pc`, `tw_alu`, `tw_chk`} to entry `tw_addr`.
  - `start` latches `trace_len`, clears idx, `cycles`, `err_count`, `first_err`, `cause` and the halt counter, then enters RUN.
  - `start` with `trace_len` = 0 goes directly to PASS.
- RUN, each cycle:
  - Entry idx is compared with the CPU inputs. A mismatch is `pc` ≠ exp_pc, or `tw_chk` set and `aluout` ≠ exp_alu.
  - `cycles` increments by 1.
  - idx increments by 1.
  - If `pc` equals the previous cycle's `pc`, the halt counter increments; otherwise it clears.
  - Writes to the trace memory are ignored.
- Mismatch handling:
  - On the first mismatch, `first_err` ← idx.
  - `err_count` increments.
  - With STOP_ON_ERR = 1, go to FAIL with cause 1.
- End of trace: when idx = trace_len−1 has just been checked, go to PASS if `err_count` (including this cycle) is 0, otherwise FAIL with cause 1.
- Early halt: the halt counter reaches HALT_REPEAT before the last entry → FAIL, cause 2.
- Timeout: `cycles` reaches TIMEOUT → FAIL, cause 3.
- Priority when several conditions hit in the same cycle: mismatch > end of trace > halt > timeout.
- PASS / FAIL: the state holds and all outputs are frozen. `start` begins a new run. `tw_en` is honoured, so the trace can be reloaded between runs.
- Reset mid-run: returns to IDLE immediately and asynchronously, with all outputs 0.

## Timing
- Compare is combinational on the current-cycle `pc`/`aluout` against the entry at registered idx. The trace memory is read asynchronously.
- All outputs are registered. `done`/`pass`/`cause` assert on the clock edge that samples the deciding cycle (1-cycle latency).
- The first compared cycle is the cycle after the `start` edge. The CPU must be released from reset so that its first `pc` appears that cycle.
- `cycles` equals the number of compared cycles when `done` rises.
- `start` asserted while in RUN is ignored.
- `tw_en` together with `start` in the same IDLE cycle: the write completes and the run uses the new value.

## Test plan
- Write 4 entries with pc 0, 4, 8, 12 and no ALU check; `trace_len` = 4; drive the same pc sequence → `done` = 1, `pass` = 1, `cycles` = 4, `err_count` = 0.
- Same trace, drive pc 0, 4, 0x10; STOP_ON_ERR = 1 → FAIL, `cause` = 1, `first_err` = 2, `cycles` = 3.
- STOP_ON_ERR = 0, entries 1 and 3 have `tw_chk` = 1 with wrong `aluout` → FAIL at end of trace, `err_count` = 2, `first_err` = 1.
- `trace_len` = 8, pc stuck at 8 from cycle 3 onward, HALT_REPEAT = 4 → `cause` = 2 after 4 repeats.
- TIMEOUT = 5, `trace_len` = 8, pc matching all entries → `cause` = 3, `cycles` = 5. Then assert `clrn` = 0 mid-run of a second test → all outputs 0 with no clock edge.
- `trace_len` = 0 with `start` → PASS on the next edge, `cycles` = 0. `trace_len` = 100 with DEPTH = 64 → clamped, run checks 64 entries.
